apu_reg_writer: RTL and testbench
=================================

// Module: apu_reg_writer
// PURPOSE
//  Write side of the APU register interface. Decodes a serial byte stream (from the UART receiver) of
//  {address, data} pairs into the $4000-$4017 register bank consumed by the pulse, triangle and
//  noise channels. Emits one toggle per channel on writes to its length/reload register
//  ($4003/$4007/$400B/$400F); channels edge-detect these toggles through their 2-flop synchronisers.
// PARAMETERS
//  TIMEOUT    8192  idle cycles allowed between address and data byte before the frame is discarded
//  TIMEOUT_W  14    width of the inter-byte timeout counter; must satisfy 2**TIMEOUT_W >= TIMEOUT
// PORTS
//  clk         in   1    system clock; single clock domain
//  rst         in   1    synchronous, active-high reset
//  rx_data     in   8    received byte; valid only while rx_valid=1
//  rx_valid    in   1    one-cycle strobe per received byte
//  apu_regs    out  192  register bank; byte n (bits 8n+7:8n) holds register $4000+n
//  reg_change  out  4    toggles: [0] $4003 pulse1, [1] $4007 pulse2, [2] $400B triangle, [3] $400F noise
//  wr_strobe   out  1    one-cycle pulse per accepted register write
//  frame_err   out  1    one-cycle pulse per discarded frame (bad address or timeout)
// BEHAVIOUR
//  - Reset: apu_regs=0, reg_change=0, wr_strobe=0, frame_err=0, FSM=ADDR, timeout counter=0.
//  - FSM ADDR: rx_valid -> latch rx_data as addr_q, clear counter, go DATA. No other action.
//  - FSM DATA: counter increments each cycle without rx_valid.
//    * rx_valid, addr_q valid: on that same edge write byte addr_q with rx_data (1-cycle latency),
//      pulse wr_strobe, toggle the matching reg_change bit if addr_q is $03/$07/$0B/$0F, go ADDR.
//    * rx_valid, addr_q invalid: no write, no toggle, pulse frame_err, go ADDR.
//    * counter reaches TIMEOUT-1 with no rx_valid: pulse frame_err, go ADDR (resync).
//    * rx_valid and timeout in same cycle: rx_valid wins; the frame is processed normally.
//  - Valid address: $00-$17 except $09, $0D, $14, $16. Unused bytes always read 0 and ignore writes.
//    Addresses $18-$FF are invalid. The full 8-bit value is compared; the block does not mask bits.
//  - Data byte is written verbatim. No side effects on other bytes. Bytes and toggles hold until rewritten/reset.
//  - Only one reg_change bit toggles per write. Back-to-back toggles are >=2 bytes apart by construction,
//    which exceeds the consumers' synchroniser requirement.
//  - Rewriting the same value still pulses wr_strobe and toggles reg_change (hardware retrigger).
//  - Reset mid-frame discards the latched address. The next byte is treated as an address.
//  - Back-to-back rx_valid on consecutive cycles is legal. Each strobe is consumed exactly once.
// STRUCTURE
//  - apu_defs.vh (shared include): register offsets ADDR_4000..ADDR_4017, REG_CHANGE bit indices,
//    FSM state encodings (ST_ADDR, ST_DATA), address-valid mask constant (24-bit).
//  - Sub-module byte_timeout: counter with clear/enable, parameterised by TIMEOUT/TIMEOUT_W,
//    expired pulse output. All remaining logic lives in apu_reg_writer.
// TESTING
//  1. rst held 3 cycles -> apu_regs==0, reg_change==4'b0000, wr_strobe==0, frame_err==0.
//  2. Bytes 0x0A,0x5D -> apu_regs[87:80]==0x5D on the edge after the 2nd strobe. wr_strobe pulses once.
//     reg_change unchanged.
//  3. Bytes 0x0B,0xF9 -> apu_regs[95:88]==0xF9, reg_change[2] 0->1. Repeat the pair -> reg_change[2] 1->0.
//     Other bits stay static.
//  4. Bytes 0x09,0x55 then 0x20,0x11 -> two frame_err pulses, apu_regs unchanged, no wr_strobe.
//  5. Byte 0x08, idle TIMEOUT cycles, then bytes 0x08,0x81 -> frame_err at timeout, apu_regs[71:64]==0x81.
//     Rerun with the data byte at TIMEOUT-1 plus the timeout in the same cycle -> write accepted, no frame_err.
//  6. Byte 0x0F, rst pulse, then bytes 0x03,0x40 -> apu_regs[31:24]==0x40, reg_change==4'b0001.
//     Byte 15 stays 0.

Source files
------------

// File: rtl/apu_reg_writer_pkg.sv
// Shared definitions for the APU register writer: register offsets, toggle indices,
// FSM encoding and address decode helpers.
package apu_reg_writer_pkg;

  localparam int unsigned NUM_REGS = 24;
  localparam int unsigned REG_W    = 8;
  localparam int unsigned BANK_W   = NUM_REGS * REG_W;
  localparam int unsigned RC_W     = 4;

  localparam logic [7:0] ADDR_4000 = 8'h00;
  localparam logic [7:0] ADDR_4003 = 8'h03;
  localparam logic [7:0] ADDR_4007 = 8'h07;
  localparam logic [7:0] ADDR_400B = 8'h0B;
  localparam logic [7:0] ADDR_400F = 8'h0F;
  localparam logic [7:0] ADDR_4017 = 8'h17;

  localparam int unsigned RC_PULSE1   = 0;
  localparam int unsigned RC_PULSE2   = 1;
  localparam int unsigned RC_TRIANGLE = 2;
  localparam int unsigned RC_NOISE    = 3;

  // Bit n set when register $4000+n exists ($09, $0D, $14, $16 are holes)
  localparam logic [NUM_REGS-1:0] ADDR_VALID_MASK = 24'hAFDDFF;

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  function automatic logic addr_valid(input logic [7:0] addr);
    logic ok;
    ok = 1'b0;
    if (addr < 8'(NUM_REGS)) ok = ADDR_VALID_MASK[addr[4:0]];
    return ok;
  endfunction

  // Length/reload registers sit at $03/$07/$0B/$0F; bits [3:2] select the channel
  function automatic logic is_reload(input logic [7:0] addr);
    return (addr[7:4] == 4'h0) && (addr[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/apu_reg_writer_byte_timeout.sv
// Inter-byte idle counter: cleared on frame start, counts enabled cycles and
// flags the cycle in which the count sits at TIMEOUT-1.
module byte_timeout #(
  parameter int unsigned TIMEOUT   = 8192,
  parameter int unsigned TIMEOUT_W = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] cnt_q;

  // Saturates at LAST so a stale count never wraps back into range
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + TIMEOUT_W'(1);
    end
  end

  assign expired_c = en && (cnt_q == LAST);

endmodule

// File: rtl/apu_reg_writer.sv
// Decodes {address, data} byte pairs from the UART into the $4000-$4017 register bank
// and emits per-channel reload toggles.
module apu_reg_writer
  import apu_reg_writer_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 8192,
  parameter int unsigned TIMEOUT_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [BANK_W-1:0]   apu_regs,
  output logic [RC_W-1:0]     reg_change,
  output logic                wr_strobe,
  output logic                frame_err
);

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       wr_c, err_c;
  logic       tmo_clr_c, tmo_en_c, expired_c;

  assign tmo_clr_c = (state_q == ST_ADDR) && rx_valid;
  assign tmo_en_c  = (state_q == ST_DATA) && !rx_valid;

  byte_timeout #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmo_clr_c),
    .en        (tmo_en_c),
    .expired_c (expired_c)
  );

  // Frame decode; rx_valid takes priority over an expiring timeout
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_c    = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      ST_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          if (addr_valid(addr_q)) wr_c = 1'b1;
          else                    err_c = 1'b1;
          state_d = ST_ADDR;
        end else if (expired_c) begin
          err_c   = 1'b1;
          state_d = ST_ADDR;
        end
      end
      default: state_d = ST_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ADDR;
      addr_q     <= '0;
      apu_regs   <= '0;
      reg_change <= '0;
      wr_strobe  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_strobe <= wr_c;
      frame_err <= err_c;
      if (wr_c) begin
        apu_regs[{addr_q[4:0], 3'b000} +: REG_W] <= rx_data;
        if (is_reload(addr_q)) reg_change[addr_q[3:2]] <= ~reg_change[addr_q[3:2]];
      end
    end
  end

endmodule

// File: tb/tb_apu_reg_writer.sv
// Self-checking bench for apu_reg_writer against a byte-array reference model.
module tb_apu_reg_writer;

  localparam int unsigned TIMEOUT   = 8192;
  localparam int unsigned TIMEOUT_W = 14;

  logic         clk;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [191:0] apu_regs;
  logic [3:0]   reg_change;
  logic         wr_strobe;
  logic         frame_err;

  apu_reg_writer #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .apu_regs   (apu_regs),
    .reg_change (reg_change),
    .wr_strobe  (wr_strobe),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [7:0] exp_regs [24];
  logic [3:0] exp_rc;
  int         exp_wr  = 0;
  int         exp_err = 0;

  // Pulse monitors: registered outputs are high for exactly one full cycle
  int wr_cnt  = 0;
  int err_cnt = 0;
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) wr_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  function automatic logic model_valid(input logic [7:0] a);
    return (a < 8'd24) && !(a inside {8'h09, 8'h0D, 8'h14, 8'h16});
  endfunction

  function automatic logic [191:0] exp_bank();
    logic [191:0] v;
    v = '0;
    for (int i = 0; i < 24; i++) v[8*i +: 8] = exp_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 24; i++) exp_regs[i] = 8'h00;
    exp_rc = 4'b0000;
  endtask

  task automatic model_frame(input logic [7:0] a, input logic [7:0] d);
    if (model_valid(a)) begin
      exp_regs[a] = d;
      exp_wr++;
      case (a)
        8'h03: exp_rc[0] = ~exp_rc[0];
        8'h07: exp_rc[1] = ~exp_rc[1];
        8'h0B: exp_rc[2] = ~exp_rc[2];
        8'h0F: exp_rc[3] = ~exp_rc[3];
        default: ;
      endcase
    end else begin
      exp_err++;
    end
  endtask

  // All stimulus tasks start and end at a falling edge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input int gap);
    send_byte(a);
    idle(gap);
    send_byte(d);
    model_frame(a, d);
  endtask

  task automatic check_state(input string name);
    n_tests++;
    if (apu_regs !== exp_bank()) begin
      n_fail++;
      $display("FAIL %s regs: got %h exp %h", name, apu_regs, exp_bank());
    end
    n_tests++;
    if (reg_change !== exp_rc) begin
      n_fail++;
      $display("FAIL %s reg_change: got %b exp %b", name, reg_change, exp_rc);
    end
  endtask

  task automatic check_counts(input string name);
    idle(2);
    n_tests++;
    if (wr_cnt !== exp_wr) begin
      n_fail++;
      $display("FAIL %s wr_strobe count: got %0d exp %0d", name, wr_cnt, exp_wr);
    end
    n_tests++;
    if (err_cnt !== exp_err) begin
      n_fail++;
      $display("FAIL %s frame_err count: got %0d exp %0d", name, err_cnt, exp_err);
    end
  endtask

  task automatic pulse_reset(input int cycles);
    rst = 1'b1;
    idle(cycles);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    pulse_reset(3);
    n_tests++;
    if (apu_regs !== 192'h0) begin
      n_fail++;
      $display("FAIL reset apu_regs: got %h exp 0", apu_regs);
    end
    n_tests++;
    if (reg_change !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset reg_change: got %b exp 0000", reg_change);
    end
    n_tests++;
    if (wr_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset wr_strobe: got %b exp 0", wr_strobe);
    end
    n_tests++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset frame_err: got %b exp 0", frame_err);
    end
  endtask

  task automatic test_write_basic();
    send_byte(8'h0A);
    idle(1);
    send_byte(8'h5D);
    model_frame(8'h0A, 8'h5D);
    n_tests++;
    if (apu_regs[87:80] !== 8'h5D) begin
      n_fail++;
      $display("FAIL write_basic byte10: got %h exp 5d", apu_regs[87:80]);
    end
    check_state("write_basic");
    check_counts("write_basic");
  endtask

  task automatic test_toggle();
    send_frame(8'h0B, 8'hF9, 0);
    n_tests++;
    if (reg_change !== 4'b0100) begin
      n_fail++;
      $display("FAIL toggle first reg_change: got %b exp 0100", reg_change);
    end
    check_state("toggle1");
    send_frame(8'h0B, 8'hF9, 1);
    n_tests++;
    if (reg_change !== 4'b0000) begin
      n_fail++;
      $display("FAIL toggle second reg_change: got %b exp 0000", reg_change);
    end
    check_state("toggle2");
    check_counts("toggle");
  endtask

  task automatic test_invalid();
    send_frame(8'h09, 8'h55, 0);
    send_frame(8'h20, 8'h11, 2);
    check_state("invalid");
    check_counts("invalid");
  endtask

  task automatic test_timeout();
    send_byte(8'h08);
    idle(TIMEOUT);
    exp_err++;
    check_counts("timeout_expire");
    send_frame(8'h08, 8'h81, 0);
    n_tests++;
    if (apu_regs[71:64] !== 8'h81) begin
      n_fail++;
      $display("FAIL timeout resync byte8: got %h exp 81", apu_regs[71:64]);
    end
    check_counts("timeout_resync");
    // Data byte lands in the last allowed cycle: accepted, no frame_err
    send_frame(8'h08, 8'h3C, TIMEOUT - 1);
    n_tests++;
    if (apu_regs[71:64] !== 8'h3C) begin
      n_fail++;
      $display("FAIL timeout edge byte8: got %h exp 3c", apu_regs[71:64]);
    end
    check_state("timeout_edge");
    check_counts("timeout_edge");
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h0F);
    pulse_reset(1);
    send_frame(8'h03, 8'h40, 1);
    n_tests++;
    if (apu_regs[31:24] !== 8'h40) begin
      n_fail++;
      $display("FAIL reset_mid byte3: got %h exp 40", apu_regs[31:24]);
    end
    n_tests++;
    if (reg_change !== 4'b0001 || apu_regs[127:120] !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid rc/byte15: got %b/%h exp 0001/00", reg_change, apu_regs[127:120]);
    end
    check_state("reset_mid");
    check_counts("reset_mid");
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, d;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 23));
      d = 8'($urandom);
      send_frame(a, d, 0);
    end
    check_state("back_to_back");
    check_counts("back_to_back");
  endtask

  task automatic test_random();
    logic [7:0] a, d;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 8'($urandom);
        1:       a = 8'($urandom_range(24, 31));
        default: a = 8'($urandom_range(0, 23));
      endcase
      d = 8'($urandom);
      send_frame(a, d, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) idle(1);
      if (i % 20 == 19) check_state("random");
    end
    check_state("random_end");
    check_counts("random_end");
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_write_basic();
    test_toggle();
    test_invalid();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
